// File: rtl/nco_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : nco_phase_gen
// Description : Initiator side of the NCO phase/sample interface for one
//               voice. A free-running prescaler produces sample-rate ticks;
//               each accepted tick advances a phase accumulator and issues
//               the top 7 phase bits to a phase-to-sample responder, then
//               waits (bounded) for the returned sample and re-registers it
//               as the voice output. Also handles tuning-word staging,
//               note-on phase reset, handshake timeout and tick overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_phase_gen #(
    parameter int ACC_W   = 24,
    parameter int DIV     = 1134,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ACC_W-1:0] tuning_word,
    input  logic             tuning_wr,
    input  logic             note_on,
    output logic [6:0]       nco_phase,
    output logic             nco_phase_dv,
    input  logic [7:0]       sample_in,
    input  logic             sample_in_dv,
    output logic [7:0]       sample_out,
    output logic             sample_out_dv,
    output logic             overrun,
    output logic             timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PHASE_W = 7;
    localparam int c_PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    // Wait counter must be able to hold TIMEOUT itself, because it is
    // incremented on the same edge that the FSM leaves WAIT.
    localparam int c_WAIT_W  = $clog2(TIMEOUT + 1);

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE   = c_WAIT_W'(1);

    // ------------------------------------------------------------------------
    // Handshake FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    logic [c_PRESC_W-1:0]   r_presc;
    logic                   w_tick;

    logic [c_WAIT_W-1:0]    r_wait_cnt;

    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_tw_active;
    logic [ACC_W-1:0]       r_tw_pending;
    logic                   r_reset_pending;
    logic [ACC_W-1:0]       w_acc_next;

    logic                   w_accept;
    logic                   w_take;
    logic                   w_overrun_set;
    logic                   w_timeout_set;

    logic [c_PHASE_W-1:0]   r_nco_phase;
    logic                   r_nco_phase_dv;
    logic [7:0]             r_sample_out;
    logic                   r_sample_out_dv;
    logic                   r_overrun;
    logic                   r_timeout;

    // ------------------------------------------------------------------------
    // Sample-rate prescaler: free-running 0..DIV-1, independent of enable
    // ------------------------------------------------------------------------
    assign w_tick = (r_presc == c_PRESC_LAST);

    // Prescaler count; wraps to zero on the tick cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Next accumulator value. A note-on arriving on the tick cycle itself is
    // honoured by that tick, so the live strobe is OR-ed with the stored flag.
    // ------------------------------------------------------------------------
    assign w_acc_next = (r_reset_pending || note_on) ? '0
                                                     : (r_acc + r_tw_active);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and per-cycle event decode
    // ------------------------------------------------------------------------
    // Decide tick acceptance, sample capture, timeout and overrun events
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_take        = 1'b0;
        w_overrun_set = 1'b0;
        w_timeout_set = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A tick with enable low is simply ignored.
                if (w_tick && enable) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The phase-valid pulse is on the output during this cycle.
                w_overrun_set = w_tick && enable;
                w_state_next  = S_WAIT;
            end

            S_WAIT: begin
                // A tick landing here is dropped; the accumulator is untouched.
                w_overrun_set = w_tick && enable;
                if (sample_in_dv) begin
                    w_take       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout_set = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // WAIT-state cycle counter, cleared while issuing
    // ------------------------------------------------------------------------
    // Count cycles spent waiting for the responder
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Phase accumulator and tuning-word staging. The active word is loaded
    // from the pending register after the add, so a newly written word only
    // affects the tick after the one that promotes it.
    // ------------------------------------------------------------------------
    // Accumulator and active tuning word advance only on accepted ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_tw_active <= '0;
        end else if (w_accept) begin
            r_acc       <= w_acc_next;
            r_tw_active <= r_tw_pending;
        end
    end

    // Capture host tuning writes into the pending register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tw_pending <= '0;
        end else if (tuning_wr) begin
            r_tw_pending <= tuning_word;
        end
    end

    // Note-on request flag, consumed by the next accepted tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reset_pending <= 1'b0;
        end else if (w_accept) begin
            r_reset_pending <= 1'b0;
        end else if (note_on) begin
            r_reset_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    // Phase to responder: loaded on tick acceptance and held until the next
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nco_phase    <= '0;
            r_nco_phase_dv <= 1'b0;
        end else begin
            r_nco_phase_dv <= w_accept;
            if (w_accept) begin
                r_nco_phase <= w_acc_next[ACC_W-1 -: c_PHASE_W];
            end
        end
    end

    // Voice sample: re-register the responder's sample when accepted in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_out    <= '0;
            r_sample_out_dv <= 1'b0;
        end else begin
            r_sample_out_dv <= w_take;
            if (w_take) begin
                r_sample_out <= sample_in;
            end
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= w_overrun_set;
            r_timeout <= w_timeout_set;
        end
    end

    assign nco_phase     = r_nco_phase;
    assign nco_phase_dv  = r_nco_phase_dv;
    assign sample_out    = r_sample_out;
    assign sample_out_dv = r_sample_out_dv;
    assign overrun       = r_overrun;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_phase_gen
// Description : Scoreboard bench for nco_phase_gen. Two instances share the
//               stimulus: one with TIMEOUT=5 and one with TIMEOUT=7, the
//               latter so a silent responder holds WAIT across the next tick
//               and exposes overrun. A transaction-level model predicts every
//               output pulse with its cycle stamp; a negedge monitor pops and
//               compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_phase_gen;

    localparam int c_ACC_W   = 24;
    localparam int c_DIV     = 8;
    localparam int c_TMO_A   = 5;
    localparam int c_TMO_B   = 7;
    localparam int c_BIG     = 32'h7fff_ffff;
    localparam int c_CH_PH   = 0;
    localparam int c_CH_SMP  = 1;
    localparam int c_CH_TMO  = 2;
    localparam int c_CH_OVR  = 3;
    localparam int c_T_B     = 1060;
    localparam int c_T_C     = 1200;
    localparam int c_T_D     = 6000;
    localparam int c_N_CYC   = 6040;

    typedef struct {
        int         stamp;
        logic [7:0] val;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [c_ACC_W-1:0] tuning_word;
    logic               tuning_wr;
    logic               note_on;
    logic [7:0]         sample_in;
    logic               sample_in_dv;

    logic [6:0]         ph     [2];
    logic               ph_dv  [2];
    logic [7:0]         so     [2];
    logic               so_dv  [2];
    logic               ovr    [2];
    logic               tmo    [2];

    int                 cyc = 0;
    int                 n_cmp = 0;
    int                 n_err = 0;
    exp_t               q [8][$];
    int                 zq [$];
    bit                 resp_plan [int];
    int                 resp_mode = 0;
    bit                 tw_done = 1'b0;
    string              ch_name [4] = '{"nco_phase", "sample_out", "timeout", "overrun"};

    // Reference model state, one slot per instance
    logic [c_ACC_W-1:0] m_acc  [2];
    logic [c_ACC_W-1:0] m_twa  [2];
    logic [c_ACC_W-1:0] m_twp  [2];
    bit                 m_rp   [2];
    bit                 m_pend [2];
    int                 m_pc   [2];
    int                 m_txn  [2];
    int                 m_idle [2];
    logic [7:0]         m_last [2];

    nco_phase_gen #(.ACC_W(c_ACC_W), .DIV(c_DIV), .TIMEOUT(c_TMO_A)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .tuning_word(tuning_word),
        .tuning_wr(tuning_wr), .note_on(note_on),
        .nco_phase(ph[0]), .nco_phase_dv(ph_dv[0]),
        .sample_in(sample_in), .sample_in_dv(sample_in_dv),
        .sample_out(so[0]), .sample_out_dv(so_dv[0]),
        .overrun(ovr[0]), .timeout(tmo[0])
    );

    nco_phase_gen #(.ACC_W(c_ACC_W), .DIV(c_DIV), .TIMEOUT(c_TMO_B)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .tuning_word(tuning_word),
        .tuning_wr(tuning_wr), .note_on(note_on),
        .nco_phase(ph[1]), .nco_phase_dv(ph_dv[1]),
        .sample_in(sample_in), .sample_in_dv(sample_in_dv),
        .sample_out(so[1]), .sample_out_dv(so_dv[1]),
        .overrun(ovr[1]), .timeout(tmo[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input int ch, input int stamp, input logic [7:0] val);
        exp_t e;
        e.stamp = stamp;
        e.val   = val;
        q[k*4 + ch].push_back(e);
    endtask

    // Schedule the responder's answer for a phase issued one cycle after c
    task automatic plan_response(input int c);
        int r;
        case (resp_mode)
            0: resp_plan[c + 3] = 1'b1;
            2: resp_plan[c + 10] = 1'b1;
            3: begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      resp_plan[c + 3] = 1'b1;
                else if (r < 8) resp_plan[c + 1 + int'($urandom_range(1, 8))] = 1'b1;
            end
            default: ;
        endcase
    endtask

    // One clock of the transaction model: inputs of cycle t, outputs at t+1
    task automatic model_step(input int k, input int tmo_cyc, input int t);
        bit tick;
        bit busy;
        bit took;
        if (rst) begin
            m_acc[k] = '0; m_twa[k] = '0; m_twp[k] = '0; m_rp[k] = 1'b0;
            m_pend[k] = 1'b0; m_pc[k] = 0; m_idle[k] = 0; m_last[k] = '0;
            return;
        end
        tick = (m_pc[k] == c_DIV - 1);
        busy = (t < m_idle[k]);
        took = 1'b0;
        if (m_pend[k]) begin
            if (sample_in_dv && t >= m_txn[k] + 2 && t <= m_txn[k] + 1 + tmo_cyc) begin
                push(k, c_CH_SMP, t + 1, sample_in);
                m_last[k] = sample_in;
                m_pend[k] = 1'b0;
                m_idle[k] = t + 1;
            end else if (t == m_txn[k] + 1 + tmo_cyc) begin
                push(k, c_CH_TMO, t + 1, m_last[k]);
                m_pend[k] = 1'b0;
                m_idle[k] = t + 1;
            end
        end
        if (tick && enable) begin
            if (busy) begin
                push(k, c_CH_OVR, t + 1, 8'h00);
            end else begin
                m_acc[k] = (m_rp[k] || note_on) ? '0 : m_acc[k] + m_twa[k];
                m_twa[k] = m_twp[k];
                m_rp[k]  = 1'b0;
                took     = 1'b1;
                push(k, c_CH_PH, t + 1, {1'b0, m_acc[k][23:17]});
                m_pend[k] = 1'b1;
                m_txn[k]  = t;
                m_idle[k] = c_BIG;
                if (k == 0) plan_response(t);
            end
        end
        if (note_on && !took) m_rp[k] = 1'b1;
        if (tuning_wr) m_twp[k] = tuning_word;
        m_pc[k] = (m_pc[k] == c_DIV - 1) ? 0 : m_pc[k] + 1;
    endtask

    // Input pattern for cycle t: reset, directed phases, then random traffic
    task automatic drive_inputs(input int t);
        rst          = 1'b0;
        tuning_wr    = 1'b0;
        note_on      = 1'b0;
        sample_in    = 8'($urandom);
        sample_in_dv = resp_plan.exists(t);
        if (sample_in_dv) resp_plan.delete(t);
        if (t <= 3) begin
            rst    = 1'b1;
            enable = 1'b0;
        end else if (t < c_T_B) begin
            enable    = 1'b1;
            resp_mode = 0;
            if (t == 4) begin
                tuning_wr   = 1'b1;
                tuning_word = 24'h020000;
            end
            if (sample_in_dv) sample_in = 8'hA5;
        end else if (t < c_T_C) begin
            enable    = 1'b1;
            resp_mode = (t < 1150) ? 0 : ((t < 1180) ? 1 : 2);
            if (!tw_done && m_pc[0] == c_DIV - 2) begin
                tuning_wr   = 1'b1;
                tuning_word = 24'h040000;
                tw_done     = 1'b1;
            end
            if (t == 1130) note_on = 1'b1;
            if (sample_in_dv && t < 1150) sample_in = 8'hA5;
        end else if (t < c_T_D) begin
            resp_mode = 3;
            rst       = ($urandom_range(0, 299) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) begin
                tuning_wr   = 1'b1;
                tuning_word = 24'($urandom);
            end
            note_on = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) sample_in_dv = 1'b1;
        end else begin
            enable    = 1'b0;
            resp_mode = 1;
        end
        if (rst) resp_plan.delete();
    endtask

    // Compare one output channel of instance k against its expectation queue
    task automatic check_chan(input int k, input int ch, input logic pulse,
                              input logic [7:0] act, input bit chk_val);
        int   idx;
        exp_t e;
        idx = k*4 + ch;
        if (pulse) begin
            n_cmp++;
            if (q[idx].size() == 0 || q[idx][0].stamp != cyc) begin
                n_err++;
                $display("FAIL %s[%0d] cycle %0d: pulse seen (value 0x%0h), expected no pulse",
                         ch_name[ch], k, cyc, act);
            end else begin
                e = q[idx].pop_front();
                if (chk_val && act !== e.val) begin
                    n_err++;
                    $display("FAIL %s[%0d] cycle %0d: value 0x%0h, expected 0x%0h",
                             ch_name[ch], k, cyc, act, e.val);
                end
            end
        end else if (q[idx].size() != 0 && q[idx][0].stamp <= cyc) begin
            n_cmp++;
            n_err++;
            e = q[idx].pop_front();
            $display("FAIL %s[%0d] cycle %0d: no pulse, expected pulse with value 0x%0h",
                     ch_name[ch], k, cyc, e.val);
        end
    endtask

    // Monitor: sample outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (cyc >= 2) begin
            for (int k = 0; k < 2; k++) begin
                check_chan(k, c_CH_PH,  ph_dv[k], {1'b0, ph[k]}, 1'b1);
                check_chan(k, c_CH_SMP, so_dv[k], so[k],         1'b1);
                check_chan(k, c_CH_TMO, tmo[k],   so[k],         1'b1);
                check_chan(k, c_CH_OVR, ovr[k],   8'h00,         1'b0);
            end
            while (zq.size() != 0 && zq[0] <= cyc) begin
                if (zq[0] == cyc) begin
                    for (int k = 0; k < 2; k++) begin
                        n_cmp++;
                        if ({ph[k], ph_dv[k], so[k], so_dv[k], ovr[k], tmo[k]} !== 19'd0) begin
                            n_err++;
                            $display("FAIL reset_state[%0d] cycle %0d: ph=0x%0h dv=%0b so=0x%0h sodv=%0b ovr=%0b tmo=%0b, expected all 0",
                                     k, cyc, ph[k], ph_dv[k], so[k], so_dv[k], ovr[k], tmo[k]);
                        end
                    end
                end
                void'(zq.pop_front());
            end
        end
    end

    // Stimulus: drive inputs just after each rising edge and step the model
    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        tuning_wr    = 1'b0;
        tuning_word  = '0;
        note_on      = 1'b0;
        sample_in    = '0;
        sample_in_dv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = '0; m_twa[k] = '0; m_twp[k] = '0; m_rp[k] = 1'b0;
            m_pend[k] = 1'b0; m_pc[k] = 0; m_txn[k] = 0; m_idle[k] = 0; m_last[k] = '0;
        end
        for (int i = 0; i < c_N_CYC; i++) begin
            @(posedge clk);
            #2;
            drive_inputs(cyc);
            if (rst) zq.push_back(cyc + 1);
            model_step(0, c_TMO_A, cyc);
            model_step(1, c_TMO_B, cyc);
        end
        @(posedge clk);
        #2;
        enable       = 1'b0;
        tuning_wr    = 1'b0;
        note_on      = 1'b0;
        sample_in_dv = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q[i].size() != 0) begin
                n_err++;
                $display("FAIL drain %s[%0d]: %0d expected pulses never seen",
                         ch_name[i % 4], i / 4, q[i].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
